// File: rtl/ras_spec_ctrl_pkg.sv
// Shared ISA constants, FSM state encoding and checkpoint record for the RAS
// speculation controller.
package ras_spec_ctrl_pkg;

    localparam int XLEN          = 32;
    localparam int RAS_PTR_WIDTH = 4;

    localparam logic [6:0] OP_J_JAL  = 7'b1101111;
    localparam logic [6:0] OP_J_JALR = 7'b1100111;
    localparam logic [4:0] REG_RA    = 5'd1;
    localparam logic [4:0] REG_T0    = 5'd5;

    typedef enum logic [1:0] {
        RSC_IDLE    = 2'd0,
        RSC_RESTORE = 2'd1,
        RSC_HOLD    = 2'd2
    } rsc_state_e;

    typedef struct packed {
        logic [RAS_PTR_WIDTH-1:0] ptr;
        logic [XLEN-1:0]          top;
    } ras_ckpt_t;

    // x1/x5 are the link registers used by the calling convention.
    function automatic logic is_link_reg(input logic [4:0] r);
        return (r == REG_RA) || (r == REG_T0);
    endfunction

endpackage

// File: rtl/ras_ckpt_fifo.sv
// Checkpoint storage for speculative RAS ops: in-order write, head retire and
// truncation of a tag plus everything younger.
module ras_ckpt_fifo
    import ras_spec_ctrl_pkg::*;
#(
    parameter int CKPT_DEPTH = 4,
    parameter int TAG_W      = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  ras_ckpt_t        wr_data,
    input  logic             retire_en,
    input  logic             trunc_en,
    input  logic [TAG_W-1:0] trunc_tag,
    input  logic [TAG_W-1:0] chk_tag,
    input  logic [TAG_W-1:0] rd_tag,
    output ras_ckpt_t        rd_data,
    output logic             chk_live,
    output logic [TAG_W-1:0] wr_idx,
    output logic [TAG_W-1:0] head_idx,
    output logic             full
);

    localparam logic [TAG_W:0] PTR_ONE = (TAG_W+1)'(1);

    logic [TAG_W:0]   wr_ptr_q, wr_ptr_d;
    logic [TAG_W:0]   rd_ptr_q, rd_ptr_d;
    logic [TAG_W:0]   count;
    logic [TAG_W-1:0] chk_off, trunc_off;
    ras_ckpt_t        ckpt_q [CKPT_DEPTH];
    ras_ckpt_t        ckpt_d [CKPT_DEPTH];

    assign wr_idx   = wr_ptr_q[TAG_W-1:0];
    assign head_idx = rd_ptr_q[TAG_W-1:0];
    assign full     = (wr_idx == head_idx) && (wr_ptr_q[TAG_W] != rd_ptr_q[TAG_W]);
    assign count    = wr_ptr_q - rd_ptr_q;
    assign rd_data  = ckpt_q[rd_tag];

    // A tag is live when its distance from the head is below the occupancy.
    assign chk_off   = chk_tag - head_idx;
    assign chk_live  = {1'b0, chk_off} < count;
    assign trunc_off = trunc_tag - head_idx;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ckpt_d   = ckpt_q;
        if (trunc_en)
            wr_ptr_d = rd_ptr_q + {1'b0, trunc_off};
        else if (wr_en) begin
            wr_ptr_d         = wr_ptr_q + PTR_ONE;
            ckpt_d[wr_idx]   = wr_data;
        end
        if (retire_en)
            rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Contents are meaningless until written, so no reset on the storage.
    always_ff @(posedge clk) begin
        ckpt_q <= ckpt_d;
    end

endmodule

// File: rtl/ras_spec_ctrl.sv
// RAS speculation controller: classifies calls/returns, drives RAS push/pop,
// checkpoints RAS state and restores it on mispredict. Optional perf counters
// under RAS_SPEC_CTRL_PERF_EN.
module ras_spec_ctrl
    import ras_spec_ctrl_pkg::*;
#(
    parameter int CKPT_DEPTH = 4,
    parameter int TAG_W      = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     f_valid,
    input  logic [6:0]               f_opcode,
    input  logic [4:0]               f_rd,
    input  logic [4:0]               f_rs1,
    input  logic [XLEN-1:0]          f_link_addr,
    output logic                     f_ready,
    output logic [TAG_W-1:0]         f_tag,
    output logic                     f_alloc,
    input  logic [RAS_PTR_WIDTH-1:0] ras_ptr,
    input  logic [XLEN-1:0]          ras_top,
    output logic                     ras_push_en,
    output logic                     ras_pop_en,
    output logic [XLEN-1:0]          ras_push_addr,
    output logic                     ras_restore_en,
    output logic [RAS_PTR_WIDTH-1:0] ras_restore_ptr,
    output logic [XLEN-1:0]          ras_restore_top,
    input  logic                     r_valid,
    input  logic [TAG_W-1:0]         r_tag,
    input  logic                     r_mispredict
`ifdef RAS_SPEC_CTRL_PERF_EN
    ,
    output logic [31:0]              perf_restores,
    output logic [31:0]              perf_full_stalls
`endif
);

    rsc_state_e       state_q, state_d;
    logic [TAG_W-1:0] rst_tag_q, rst_tag_d;

    logic             is_jal, is_jalr, is_call, is_ret, op_req;
    logic             mp_take, retire, accept;
    logic             r_live, full;
    logic [TAG_W-1:0] wr_idx, head_idx;
    ras_ckpt_t        rd_data;

    always_comb begin
        is_jal  = (f_opcode == OP_J_JAL);
        is_jalr = (f_opcode == OP_J_JALR);
        is_call = (is_jal || is_jalr) && is_link_reg(f_rd);
        is_ret  = is_jalr && is_link_reg(f_rs1) && !is_link_reg(f_rd);
        op_req  = f_valid && (is_call || is_ret);
        mp_take = r_valid && r_mispredict && (state_q == RSC_IDLE) && r_live;
        retire  = r_valid && !r_mispredict && r_live && (r_tag == head_idx);
        // A taken mispredict flushes the fetch stream, so nothing is accepted.
        f_ready = (state_q == RSC_IDLE) && !full && !mp_take;
        accept  = op_req && f_ready;
    end

    assign ras_push_en     = accept && is_call;
    assign ras_pop_en      = accept && is_ret;
    assign ras_push_addr   = ras_push_en ? f_link_addr : '0;
    assign f_alloc         = accept;
    assign f_tag           = accept ? wr_idx : '0;
    assign ras_restore_en  = (state_q == RSC_RESTORE);
    assign ras_restore_ptr = ras_restore_en ? rd_data.ptr : '0;
    assign ras_restore_top = ras_restore_en ? rd_data.top : '0;

    ras_ckpt_fifo #(
        .CKPT_DEPTH (CKPT_DEPTH),
        .TAG_W      (TAG_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (accept),
        .wr_data   ({ras_ptr, ras_top}),
        .retire_en (retire),
        .trunc_en  (mp_take),
        .trunc_tag (r_tag),
        .chk_tag   (r_tag),
        .rd_tag    (rst_tag_q),
        .rd_data   (rd_data),
        .chk_live  (r_live),
        .wr_idx    (wr_idx),
        .head_idx  (head_idx),
        .full      (full)
    );

    always_comb begin
        state_d   = state_q;
        rst_tag_d = rst_tag_q;
        case (state_q)
            RSC_IDLE: begin
                if (mp_take) begin
                    state_d   = RSC_RESTORE;
                    rst_tag_d = r_tag;
                end
            end
            RSC_RESTORE: state_d = RSC_HOLD;
            RSC_HOLD:    state_d = RSC_IDLE;
            default:     state_d = RSC_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= RSC_IDLE;
            rst_tag_q <= '0;
        end else begin
            state_q   <= state_d;
            rst_tag_q <= rst_tag_d;
        end
    end

`ifdef RAS_SPEC_CTRL_PERF_EN
    logic [31:0] perf_restores_q, perf_restores_d;
    logic [31:0] perf_full_stalls_q, perf_full_stalls_d;

    always_comb begin
        perf_restores_d    = perf_restores_q;
        perf_full_stalls_d = perf_full_stalls_q;
        if (ras_restore_en && !(&perf_restores_q))
            perf_restores_d = perf_restores_q + 32'd1;
        if (op_req && full && !(&perf_full_stalls_q))
            perf_full_stalls_d = perf_full_stalls_q + 32'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_restores_q    <= '0;
            perf_full_stalls_q <= '0;
        end else begin
            perf_restores_q    <= perf_restores_d;
            perf_full_stalls_q <= perf_full_stalls_d;
        end
    end

    assign perf_restores    = perf_restores_q;
    assign perf_full_stalls = perf_full_stalls_q;
`endif

endmodule

// File: tb/tb_ras_spec_ctrl.sv
// Directed self-checking bench for ras_spec_ctrl; perf counters are exercised
// when RAS_SPEC_CTRL_PERF_EN is defined.
module tb_ras_spec_ctrl;
    import ras_spec_ctrl_pkg::*;

    localparam int TAG_W = 2;
    localparam logic [6:0] OP_ADDI = 7'b0010011;

    logic                     clk, reset;
    logic                     f_valid;
    logic [6:0]               f_opcode;
    logic [4:0]               f_rd, f_rs1;
    logic [XLEN-1:0]          f_link_addr;
    logic                     f_ready, f_alloc;
    logic [TAG_W-1:0]         f_tag;
    logic [RAS_PTR_WIDTH-1:0] ras_ptr;
    logic [XLEN-1:0]          ras_top;
    logic                     ras_push_en, ras_pop_en, ras_restore_en;
    logic [XLEN-1:0]          ras_push_addr, ras_restore_top;
    logic [RAS_PTR_WIDTH-1:0] ras_restore_ptr;
    logic                     r_valid, r_mispredict;
    logic [TAG_W-1:0]         r_tag;
`ifdef RAS_SPEC_CTRL_PERF_EN
    logic [31:0]              perf_restores, perf_full_stalls;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    ras_spec_ctrl #(.CKPT_DEPTH(4), .TAG_W(TAG_W)) dut (
        .clk             (clk),
        .reset           (reset),
        .f_valid         (f_valid),
        .f_opcode        (f_opcode),
        .f_rd            (f_rd),
        .f_rs1           (f_rs1),
        .f_link_addr     (f_link_addr),
        .f_ready         (f_ready),
        .f_tag           (f_tag),
        .f_alloc         (f_alloc),
        .ras_ptr         (ras_ptr),
        .ras_top         (ras_top),
        .ras_push_en     (ras_push_en),
        .ras_pop_en      (ras_pop_en),
        .ras_push_addr   (ras_push_addr),
        .ras_restore_en  (ras_restore_en),
        .ras_restore_ptr (ras_restore_ptr),
        .ras_restore_top (ras_restore_top),
        .r_valid         (r_valid),
        .r_tag           (r_tag),
        .r_mispredict    (r_mispredict)
`ifdef RAS_SPEC_CTRL_PERF_EN
        ,
        .perf_restores    (perf_restores),
        .perf_full_stalls (perf_full_stalls)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_f(input logic v, input logic [6:0] op, input logic [4:0] rd,
                           input logic [4:0] rs1, input logic [XLEN-1:0] link,
                           input logic [RAS_PTR_WIDTH-1:0] rp, input logic [XLEN-1:0] rt);
        f_valid = v; f_opcode = op; f_rd = rd; f_rs1 = rs1;
        f_link_addr = link; ras_ptr = rp; ras_top = rt;
        #1;
    endtask

    task automatic drive_r(input logic v, input logic [TAG_W-1:0] t, input logic mp);
        r_valid = v; r_tag = t; r_mispredict = mp;
        #1;
    endtask

    initial begin
        reset = 1'b1;
        drive_f(1'b0, 7'd0, 5'd0, 5'd0, '0, '0, '0);
        drive_r(1'b0, '0, 1'b0);
        #1;
        chk("rst_ready", f_ready, 1);
        chk("rst_push", ras_push_en, 0);
        chk("rst_pop", ras_pop_en, 0);
        chk("rst_alloc", f_alloc, 0);
        chk("rst_restore", ras_restore_en, 0);
        tick();
        reset = 1'b0;

        // call via JAL x1
        drive_f(1'b1, OP_J_JAL, 5'd1, 5'd0, 32'h104, 4'd2, 32'hAAAA_0000);
        chk("call_push", ras_push_en, 1);
        chk("call_addr", ras_push_addr, 32'h104);
        chk("call_pop", ras_pop_en, 0);
        chk("call_tag", f_tag, 0);
        chk("call_alloc", f_alloc, 1);
        chk("call_ready", f_ready, 1);
        tick();

        // return: JALR rs1=x1 rd=x0
        drive_f(1'b1, OP_J_JALR, 5'd0, 5'd1, 32'h208, 4'd3, 32'h104);
        chk("ret_pop", ras_pop_en, 1);
        chk("ret_push", ras_push_en, 0);
        chk("ret_tag", f_tag, 1);
        tick();

        // rd and rs1 both link: call wins
        drive_f(1'b1, OP_J_JALR, 5'd1, 5'd1, 32'h30C, 4'd2, 32'hBBBB_0000);
        chk("prec_push", ras_push_en, 1);
        chk("prec_pop", ras_pop_en, 0);
        chk("prec_tag", f_tag, 2);
        tick();

        drive_f(1'b1, OP_ADDI, 5'd1, 5'd1, 32'h0, 4'd2, 32'h0);
        chk("nonjmp_alloc", f_alloc, 0);
        drive_f(1'b1, OP_J_JAL, 5'd0, 5'd1, 32'h0, 4'd2, 32'h0);
        chk("jal_x0_alloc", f_alloc, 0);
        chk("jal_x0_pop", ras_pop_en, 0);
        tick();

        // mispredict tag1 together with a call: call dropped
        drive_r(1'b1, 2'd1, 1'b1);
        drive_f(1'b1, OP_J_JAL, 5'd5, 5'd0, 32'h300, 4'd4, 32'hCCCC_0000);
        chk("mp_acc_ready", f_ready, 0);
        chk("mp_acc_push", ras_push_en, 0);
        chk("mp_acc_alloc", f_alloc, 0);
        tick();
        drive_r(1'b0, '0, 1'b0);
        drive_f(1'b0, 7'd0, 5'd0, 5'd0, '0, '0, '0);
        chk("restore_en", ras_restore_en, 1);
        chk("restore_ptr", ras_restore_ptr, 3);
        chk("restore_top", ras_restore_top, 32'h104);
        chk("restore_ready", f_ready, 0);
        tick();
        // HOLD: a mispredict here must be ignored
        drive_r(1'b1, 2'd0, 1'b1);
        chk("hold_restore", ras_restore_en, 0);
        chk("hold_ready", f_ready, 0);
        tick();
        drive_r(1'b0, '0, 1'b0);
        drive_f(1'b1, OP_J_JAL, 5'd1, 5'd0, 32'h400, 4'd5, 32'hDDDD_0000);
        chk("idle_restore", ras_restore_en, 0);
        chk("idle_ready", f_ready, 1);
        chk("trunc_tag", f_tag, 1);
        tick();

        // retire head tag0
        drive_f(1'b0, 7'd0, 5'd0, 5'd0, '0, '0, '0);
        drive_r(1'b1, 2'd0, 1'b0);
        tick();
        drive_r(1'b0, '0, 1'b0);

        // fill: tags 2,3,0
        for (int i = 0; i < 3; i++) begin
            drive_f(1'b1, OP_J_JAL, 5'd1, 5'd0, 32'h500 + 32'(i * 4),
                    RAS_PTR_WIDTH'(6 + i), 32'hE000 + 32'(i));
            chk("fill_tag", f_tag, (2 + i) % 4);
            tick();
        end
        chk("full_ready", f_ready, 0);
        chk("full_push", ras_push_en, 0);
        chk("full_alloc", f_alloc, 0);
        drive_r(1'b1, 2'd2, 1'b0);
        tick();
        chk("nonhead_ready", f_ready, 0);
        drive_r(1'b1, 2'd1, 1'b0);
        chk("full_retire_ready", f_ready, 0);
        chk("full_retire_push", ras_push_en, 0);
        tick();
        drive_r(1'b0, '0, 1'b0);
        drive_f(1'b0, 7'd0, 5'd0, 5'd0, '0, '0, '0);
        chk("after_retire_ready", f_ready, 1);

        // tag1 is no longer in flight (in flight: 2,3,0)
        drive_r(1'b1, 2'd1, 1'b1);
        chk("stale_mp_ready", f_ready, 1);
        tick();
        drive_r(1'b0, '0, 1'b0);
        chk("stale_mp_restore", ras_restore_en, 0);

        // reset in RESTORE
        drive_r(1'b1, 2'd3, 1'b1);
        tick();
        drive_r(1'b0, '0, 1'b0);
        chk("rst3_en", ras_restore_en, 1);
        chk("rst3_ptr", ras_restore_ptr, 7);
        chk("rst3_top", ras_restore_top, 32'hE001);
        reset = 1'b1;
        #1;
        chk("midrst_restore", ras_restore_en, 0);
        chk("midrst_ready", f_ready, 1);
        tick();
        reset = 1'b0;
        drive_f(1'b1, OP_J_JAL, 5'd1, 5'd0, 32'h600, 4'd1, 32'h0);
        chk("postrst_tag", f_tag, 0);
        chk("postrst_alloc", f_alloc, 1);
        tick();
        drive_f(1'b0, 7'd0, 5'd0, 5'd0, '0, '0, '0);

`ifdef RAS_SPEC_CTRL_PERF_EN
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("perf_rst_restores", perf_restores, 0);
        chk("perf_rst_stalls", perf_full_stalls, 0);
        drive_f(1'b1, OP_J_JAL, 5'd1, 5'd0, 32'h700, 4'd1, 32'h0);
        for (int i = 0; i < 4; i++) tick();
        for (int i = 0; i < 5; i++) tick();
        drive_f(1'b0, 7'd0, 5'd0, 5'd0, '0, '0, '0);
        chk("perf_stalls", perf_full_stalls, 5);
        for (int k = 3; k >= 1; k--) begin
            drive_r(1'b1, TAG_W'(k), 1'b1);
            tick();
            drive_r(1'b0, '0, 1'b0);
            tick();
            tick();
        end
        chk("perf_restores", perf_restores, 3);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
